alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the issued-operation counter.
REQ-002 The block SHALL have port ck, input, 1, the single rising-edge clock shared with the ALU.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 each, requester n has an operation pending.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 each, grant to requester n this cycle.
REQ-006 The block SHALL have ports req0_a/req1_a and req0_b/req1_b, input, 8 each, operands of requester n.
REQ-007 The block SHALL have ports req0_ctr and req1_ctr, input, 4 each, ALU op code of requester n.
REQ-008 The block SHALL have ports alu_a and alu_b, output, 8 each, and alu_ctr, output, 4, which drive the ALU A, B and CTR inputs.
REQ-009 The block SHALL have port alu_o, input, 8, the ALU result output.
REQ-010 The block SHALL have port rsp_valid, output, 1, a one-cycle result strobe.
REQ-011 The block SHALL have port rsp_id, output, 1, the requester that owns the result.
REQ-012 The block SHALL have port rsp_data, output, 8, the result value.
REQ-013 The block SHALL have port rsp_zero, output, 1, asserted when rsp_data==0.
REQ-014 The block SHALL have port busy, output, 1, asserted when any operation is in flight.
REQ-015 The block SHALL have port ops_cnt, output, CTR_W=CNT_W, the count of accepted operations.

Function
REQ-016 Handshake: a requester's transfer SHALL occur on a rising edge where req_valid and req_ready are both 1; req_ready SHALL be combinational from the valid inputs and the priority state, and SHALL never be 1 for both requesters.
REQ-017 With exactly one valid requester, that requester SHALL be granted in the same cycle; throughput SHALL be one operation per cycle, with no idle bubbles.
REQ-018 When both requesters are valid, the grant SHALL go to the requester not granted last (round robin); the last-grant pointer SHALL update only on a transfer.
REQ-019 alu_a, alu_b and alu_ctr SHALL be a combinational mux of the granted requester's fields, and SHALL be 0 when there is no grant.
REQ-020 Latency: the ALU captures its inputs at transfer edge E and updates alu_o at E+1; the block SHALL register alu_o at E+2, so rsp_valid=1 for exactly the cycle following E+2.
REQ-021 The block SHALL carry the requester id through a 2-stage valid+id shift register; rsp_id SHALL equal the id of the transfer at E.
REQ-022 Back-to-back transfers SHALL produce back-to-back rsp_valid pulses in issue order, with no loss and no reordering.
REQ-023 rsp_data and rsp_zero SHALL hold their last values while rsp_valid=0.
REQ-024 busy SHALL be the OR of the two tag-stage valids and of rsp_valid.
REQ-025 ops_cnt SHALL increment by 1 per transfer and SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 The block SHALL not decode op codes; an undefined op code SHALL still be issued, and its result (alu_o as produced) SHALL be returned normally.

Reset
REQ-027 While rst_n=0, the block SHALL hold every register at its reset value: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, busy=0, ops_cnt=0, tag stages invalid, and the last-grant pointer at requester 1 so that requester 0 wins the first contention.
REQ-028 An assertion of rst_n mid-operation SHALL discard all in-flight operations, with no rsp_valid for them after release.
REQ-029 req_ready SHALL be 0 while rst_n=0.

Configuration
REQ-030 With macro ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win contention and the last-grant pointer SHALL be omitted.
REQ-031 With ALU_ARB_FIXED_PRIO_EN undefined, round robin per REQ-018 SHALL apply.

Verification
REQ-032 Single-op scenario: req0 issues A=8'h05, B=8'h03, CTR=4'b0000 -> rsp_valid is a single pulse 3 cycles after the transfer cycle, with rsp_id=0, rsp_data=8'h08, rsp_zero=0.
REQ-033 Contention scenario (round robin): both requesters hold valid for 4 cycles (req0 CTR=0001, A=B=8'h22; req1 CTR=1110, A=8'h01) -> grants 0,1,0,1, and responses alternate 8'h00 (rsp_zero=1) and 8'h80.
REQ-034 Contention scenario (ALU_ARB_FIXED_PRIO_EN defined): the same stimulus -> req0_ready=1 on all 4 cycles, req1 is starved, and ops_cnt=4.
REQ-035 Reset scenario: rst_n is pulsed low one cycle after two transfers -> no rsp_valid follows, and all outputs read 0.
REQ-036 Wrap scenario: with CNT_W=4, 17 transfers -> ops_cnt=1; a streaming check confirms 17 in-order responses with matching rsp_id.

Source files
------------

// File: rtl/alu_arb.sv
// -----------------------------------------------------------------------------
// alu_arb -- two-requester front end for a shared, one-cycle-pipelined ALU.
//
// The block picks one requester per cycle and muxes that requester's operands
// and op code onto the ALU inputs. A valid+id tag follows each issued
// operation down a two-stage shift register. When the ALU result for the
// operation is available, the block captures it and presents it with a
// one-cycle rsp_valid strobe. Op codes are passed through without decoding.
//
// Arbitration:
//   default                       round robin. On contention the grant goes to
//                                 the requester not granted last. The pointer
//                                 resets to requester 1, so requester 0 wins
//                                 the first contention.
//   ALU_ARB_FIXED_PRIO_EN defined requester 0 always wins, and there is no
//                                 last-grant pointer.
//
// Parameters:
//   CNT_W          width of the ops_cnt issued-operation counter
//
// Ports:
//   ck             rising-edge clock shared with the ALU
//   rst_n          asynchronous active-low reset
//   reqN_valid     requester N has an operation pending
//   reqN_ready     grant to requester N this cycle (combinational)
//   reqN_a/_b/_ctr operands and op code of requester N
//   alu_a/_b/_ctr  drive the ALU inputs; 0 when nothing is granted
//   alu_o          ALU result, one cycle after the ALU captured its inputs
//   rsp_valid      one-cycle result strobe
//   rsp_id         requester that owns the result
//   rsp_data       result value; holds while rsp_valid=0
//   rsp_zero       rsp_data==0; holds while rsp_valid=0
//   busy           an operation is in flight
//   ops_cnt        count of accepted operations, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_arb #(
  parameter int CNT_W = 16
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [3:0]       req0_ctr,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [3:0]       req1_ctr,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_ctr,
  input  logic [7:0]       alu_o,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] ops_cnt
);

  logic gnt0;
  logic gnt1;
  logic vld_p0;
  logic id_p0;
  logic vld_p1;
  logic id_p1;
  logic vld_p2;
  logic id_p2;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Requester that won the most recent transfer (0 or 1).
  logic last_gnt;
`endif

  // ---- stage p0: arbitration and issue to the ALU ----
  // Grants are forced low during reset so nothing can transfer while the
  // tag pipeline is being cleared.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign vld_p0     = gnt0 | gnt1;
  assign id_p0      = gnt1;

  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_ctr = 4'h0;
    if (gnt0) begin
      alu_a   = req0_a;
      alu_b   = req0_b;
      alu_ctr = req0_ctr;
    end else if (gnt1) begin
      alu_a   = req1_a;
      alu_b   = req1_b;
      alu_ctr = req1_ctr;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (vld_p0) begin
      last_gnt <= id_p0;
    end
  end
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt <= '0;
    end else if (vld_p0) begin
      ops_cnt <= ops_cnt + CNT_W'(1);
    end
  end

  // ---- stage p1: the ALU has captured its inputs ----
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      id_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      id_p1  <= id_p0;
    end
  end

  // ---- stage p2: alu_o holds the result for this tag ----
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      id_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  // ---- response register ----
  // Data and zero flag load only with a valid tag, so they hold between
  // results.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_zero  <= 1'b0;
    end else begin
      rsp_valid <= vld_p2;
      if (vld_p2) begin
        rsp_id   <= id_p2;
        rsp_data <= alu_o;
        rsp_zero <= (alu_o == 8'h00);
      end
    end
  end

  assign busy = vld_p1 | vld_p2 | rsp_valid;

endmodule

// File: tb/tb_alu_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_arb -- self-checking bench for alu_arb.
//
// A small pipelined ALU model closes the loop. It registers alu_a, alu_b and
// alu_ctr on one edge and produces alu_o on the next.
//
// The reference model works at the transaction level. It decides the expected
// grant from the arbitration rule. On each accepted operation it computes the
// ALU result and queues {due cycle, id, result}. Each cycle it compares every
// output against what that queue and a few scalars predict.
//
// Build with ALU_ARB_FIXED_PRIO_EN defined to check the fixed-priority
// variant.
// -----------------------------------------------------------------------------
module tb_alu_arb;

  localparam int CNT_W = 4;

  logic             ck = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0;
  logic             req1_valid = 1'b0;
  logic             req0_ready;
  logic             req1_ready;
  logic [7:0]       req0_a = 8'h00;
  logic [7:0]       req0_b = 8'h00;
  logic [3:0]       req0_ctr = 4'h0;
  logic [7:0]       req1_a = 8'h00;
  logic [7:0]       req1_b = 8'h00;
  logic [3:0]       req1_ctr = 4'h0;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_ctr;
  logic [7:0]       alu_o = 8'h00;
  logic             rsp_valid;
  logic             rsp_id;
  logic [7:0]       rsp_data;
  logic             rsp_zero;
  logic             busy;
  logic [CNT_W-1:0] ops_cnt;

  alu_arb #(.CNT_W(CNT_W)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_ctr  (req0_ctr),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_ctr  (req1_ctr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctr   (alu_ctr),
    .alu_o     (alu_o),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .busy      (busy),
    .ops_cnt   (ops_cnt)
  );

  always #5 ck = ~ck;

  // ALU behaviour. Codes outside the listed set still produce a value.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] c);
    case (c)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'hE:    return {a[0], a[7:1]};
      default: return ~(a ^ b) + {4'h0, c};
    endcase
  endfunction

  // Pipelined ALU model: inputs captured at E, result visible after E+1.
  logic [7:0] q_a = 8'h00;
  logic [7:0] q_b = 8'h00;
  logic [3:0] q_c = 4'h0;
  always @(posedge ck) begin
    q_a   <= alu_a;
    q_b   <= alu_b;
    q_c   <= alu_ctr;
    alu_o <= alu_fn(q_a, q_b, q_c);
  end

  // Reference model state.
  typedef struct {
    int         due;
    bit         id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         m_cnt = 0;
  bit         m_last = 1'b1;
  logic [7:0] m_data = 8'h00;
  bit         m_zero = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Compare all outputs for the current cycle, then advance the model past
  // the coming clock edge.
  task automatic evaluate();
    bit         g0;
    bit         g1;
    bit         exp_busy;
    exp_t       e;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [3:0] ec;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt  = 0;
      m_last = 1'b1;
      m_data = 8'h00;
      m_zero = 1'b0;
      check("rst_ready0", {31'd0, req0_ready}, 0);
      check("rst_ready1", {31'd0, req1_ready}, 0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      check("rst_rsp_id", {31'd0, rsp_id}, 0);
      check("rst_rsp_data", {24'd0, rsp_data}, 0);
      check("rst_rsp_zero", {31'd0, rsp_zero}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_ops_cnt", {28'd0, ops_cnt}, 0);
    end else begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        g0 = 1'b1;
`else
        if (m_last) g0 = 1'b1;
        else        g1 = 1'b1;
`endif
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
      check("ready0", {31'd0, req0_ready}, {31'd0, g0});
      check("ready1", {31'd0, req1_ready}, {31'd0, g1});

      ea = 8'h00; eb = 8'h00; ec = 4'h0;
      if (g0) begin
        ea = req0_a; eb = req0_b; ec = req0_ctr;
      end else if (g1) begin
        ea = req1_a; eb = req1_b; ec = req1_ctr;
      end
      check("alu_a", {24'd0, alu_a}, {24'd0, ea});
      check("alu_b", {24'd0, alu_b}, {24'd0, eb});
      check("alu_ctr", {28'd0, alu_ctr}, {28'd0, ec});

      // Everything still queued is due within the next three cycles.
      exp_busy = (exp_q.size() != 0);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        m_data = e.data;
        m_zero = (e.data == 8'h00);
        check("rsp_valid", {31'd0, rsp_valid}, 1);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
      end else begin
        check("rsp_valid_idle", {31'd0, rsp_valid}, 0);
      end
      check("rsp_data", {24'd0, rsp_data}, {24'd0, m_data});
      check("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("ops_cnt", {28'd0, ops_cnt}, m_cnt);

      if (g0 || g1) begin
        e.due  = cyc + 3;
        e.id   = g1;
        e.data = alu_fn(ea, eb, ec);
        exp_q.push_back(e);
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_last = g1;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit rn, input bit v0, input bit v1,
                      input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] c0,
                      input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] c1);
    @(negedge ck);
    rst_n      = rn;
    req0_valid = v0;
    req1_valid = v1;
    req0_a     = a0;
    req0_b     = b0;
    req0_ctr   = c0;
    req1_a     = a1;
    req1_b     = b1;
    req1_ctr   = c1;
    #1;
    evaluate();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 4'h3, 8'h44, 8'h55, 4'h6);
  endtask

  initial begin
    bit exp_g0;

    do_reset(2);

    // Single operation: 5 + 3 from requester 0.
    step(1'b1, 1'b1, 1'b0, 8'h05, 8'h03, 4'h0, 8'h00, 8'h00, 4'h0);
    idle(2);
    check("single_not_yet", {31'd0, rsp_valid}, 0);
    idle(1);
    check("single_valid", {31'd0, rsp_valid}, 1);
    check("single_data", {24'd0, rsp_data}, 32'h08);
    check("single_id", {31'd0, rsp_id}, 0);
    check("single_zero", {31'd0, rsp_zero}, 0);
    idle(2);

    // Contention: both requesters hold valid for four cycles.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h22, 8'h22, 4'h1, 8'h01, 8'h00, 4'hE);
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g0 = 1'b1;
`else
      exp_g0 = (i % 2 == 0);
`endif
      check("cont_grant0", {31'd0, req0_ready}, {31'd0, exp_g0});
    end
    idle(1);
    check("cont_ops_cnt", {28'd0, ops_cnt}, 4);
    idle(1);
    check("cont_rsp1_data", {24'd0, rsp_data}, 32'h00);
    check("cont_rsp1_zero", {31'd0, rsp_zero}, 1);
    idle(1);
`ifndef ALU_ARB_FIXED_PRIO_EN
    check("cont_rsp2_data", {24'd0, rsp_data}, 32'h80);
`endif
    idle(3);

    // Reset one cycle after two transfers discards both.
    step(1'b1, 1'b1, 1'b0, 8'h10, 8'h20, 4'h0, 8'h00, 8'h00, 4'h0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h30, 8'h01, 4'h1);
    idle(1);
    do_reset(1);
    idle(5);
    check("rst_flush_data", {24'd0, rsp_data}, 0);
    check("rst_flush_cnt", {28'd0, ops_cnt}, 0);

    // Counter wrap: 17 streaming transfers with a 4-bit counter.
    do_reset(1);
    for (int i = 0; i < 17; i++)
      step(1'b1, (i % 3) != 2, (i % 3) == 2, 8'($urandom), 8'($urandom), 4'($urandom),
           8'($urandom), 8'($urandom), 4'($urandom));
    idle(1);
    check("wrap_ops_cnt", {28'd0, ops_cnt}, 1);
    idle(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
    idle(5);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
